// File: rtl/gift_shop_pkg.sv
// rtl/gift_shop_pkg.sv - shared widths, FSM state type and BCD constant tables
package gift_shop_pkg;

  localparam int BCD_W  = 40;
  localparam int WORD_W = 32;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [2:0] {
    COLLECT,
    SPLIT,
    EMIT,
    DRAIN,
    DONE
  } sched_state_e;

  // Indexed by digit count: smallest and largest BCD value with that many digits
  localparam bcd_t POW10_TBL [11] = '{
    40'h0, 40'h1, 40'h10, 40'h100, 40'h1000, 40'h10000, 40'h100000,
    40'h1000000, 40'h10000000, 40'h100000000, 40'h1000000000
  };

  localparam bcd_t NINES_TBL [11] = '{
    40'h0, 40'h9, 40'h99, 40'h999, 40'h9999, 40'h99999, 40'h999999,
    40'h9999999, 40'h99999999, 40'h999999999, 40'h9999999999
  };

endpackage

// File: rtl/range_scheduler_if.sv
// rtl/range_scheduler_if.sv - range word input and segment output handshakes
interface range_scheduler_if;
  import gift_shop_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  bcd_t              seg_start;
  bcd_t              seg_end;
  logic [3:0]        seg_len;
  logic              seg_valid;
  logic              seg_ready;
  logic              seg_done;

  modport master (
    output in_data, in_valid, seg_ready, seg_done,
    input  in_ready, seg_start, seg_end, seg_len, seg_valid
  );

  modport slave (
    input  in_data, in_valid, seg_ready, seg_done,
    output in_ready, seg_start, seg_end, seg_len, seg_valid
  );

endinterface

// File: rtl/bcd_digit_len.sv
// rtl/bcd_digit_len.sv - digit count of a BCD value (zero counts as one digit)
module bcd_digit_len
  import gift_shop_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [3:0] len_o
);

  always_comb begin
    len_o = 4'd1;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_i[4*i +: 4] != 4'h0) len_o = 4'(i + 1);
    end
  end

endmodule

// File: rtl/range_scheduler.sv
// rtl/range_scheduler.sv - splits BCD ranges into even-digit-length segments
module range_scheduler
  import gift_shop_pkg::*;
#(
  parameter int NUM_RANGES      = 34,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  range_scheduler_if.slave bus,
  output logic [15:0]      seg_count,
  output logic             finished
);

  localparam int RW = $clog2(NUM_RANGES + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  sched_state_e  state_q;
  logic [1:0]    word_q;
  logic [RW-1:0] range_q;
  logic [79:0]   buf_q;
  logic [3:0]    len_s_q, len_e_q, cur_len_q;
  logic [OW-1:0] out_q, out_d;
  logic [15:0]   count_q;
  logic          in_ready_q, seg_valid_q, finished_q;
  bcd_t          seg_start_q, seg_end_q;
  logic [3:0]    seg_len_q;

  bcd_t       start_w, end_w;
  logic [3:0] len_s, len_e;
  logic       in_hs, seg_hs, done_ok, more_ranges;

  assign start_w     = buf_q[79:40];
  assign end_w       = buf_q[39:0];
  assign in_hs       = bus.in_valid && in_ready_q;
  assign seg_hs      = seg_valid_q && bus.seg_ready;
  assign done_ok     = bus.seg_done && (out_q != '0);
  assign more_ranges = range_q < RW'(NUM_RANGES);

  bcd_digit_len u_len_s (.bcd_i(start_w), .len_o(len_s));
  bcd_digit_len u_len_e (.bcd_i(end_w),   .len_o(len_e));

  always_comb begin
    out_d = out_q;
    if (seg_hs && !done_ok)      out_d = out_q + OW'(1);
    else if (!seg_hs && done_ok) out_d = out_q - OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      count_q <= '0;
    end else begin
      out_q <= out_d;
      if (seg_hs && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      word_q      <= '0;
      range_q     <= '0;
      buf_q       <= '0;
      len_s_q     <= '0;
      len_e_q     <= '0;
      cur_len_q   <= '0;
      in_ready_q  <= 1'b0;
      seg_valid_q <= 1'b0;
      finished_q  <= 1'b0;
      seg_start_q <= '0;
      seg_end_q   <= '0;
      seg_len_q   <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          in_ready_q <= more_ranges;
          if (in_hs) begin
            case (word_q)
              2'd0:    buf_q[31:0]  <= bus.in_data;
              2'd1:    buf_q[63:32] <= bus.in_data;
              default: buf_q[79:64] <= bus.in_data[15:0];
            endcase
            if (word_q == 2'd2) begin
              word_q     <= '0;
              range_q    <= range_q + 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= SPLIT;
            end else begin
              word_q <= word_q + 2'd1;
            end
          end
        end
        SPLIT: begin
          len_s_q   <= len_s;
          len_e_q   <= len_e;
          cur_len_q <= len_s;
          // BCD digits order like binary nibbles, so a plain compare is numeric
          if (start_w > end_w) begin
            state_q    <= more_ranges ? COLLECT : DRAIN;
            in_ready_q <= more_ranges;
          end else begin
            state_q <= EMIT;
          end
        end
        EMIT: begin
          // Odd lengths hold no even-digit numbers and just burn one idle cycle
          if ((seg_valid_q && bus.seg_ready) || (!seg_valid_q && cur_len_q[0])) begin
            seg_valid_q <= 1'b0;
            cur_len_q   <= cur_len_q + 4'd1;
            if (cur_len_q >= len_e_q) begin
              state_q    <= more_ranges ? COLLECT : DRAIN;
              in_ready_q <= more_ranges;
            end
          end else if (!seg_valid_q && out_d < OW'(MAX_OUTSTANDING)) begin
            seg_valid_q <= 1'b1;
            seg_start_q <= (cur_len_q == len_s_q) ? start_w : POW10_TBL[cur_len_q];
            seg_end_q   <= (cur_len_q == len_e_q) ? end_w : NINES_TBL[cur_len_q];
            seg_len_q   <= cur_len_q;
          end
        end
        DRAIN: begin
          if (out_d == '0) begin
            state_q    <= DONE;
            finished_q <= 1'b1;
          end
        end
        DONE: begin
          finished_q <= 1'b1;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.seg_valid = seg_valid_q;
  assign bus.seg_start = seg_start_q;
  assign bus.seg_end   = seg_end_q;
  assign bus.seg_len   = seg_len_q;
  assign seg_count     = count_q;
  assign finished      = finished_q;

endmodule

// File: tb/tb_range_scheduler.sv
// tb/tb_range_scheduler.sv - scoreboard bench for range_scheduler
module tb_range_scheduler;
  import gift_shop_pkg::*;

  typedef struct packed {
    bcd_t       s;
    bcd_t       e;
    logic [3:0] l;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] seg_count;
  logic        finished;

  range_scheduler_if bus ();

  range_scheduler #(.NUM_RANGES(2), .MAX_OUTSTANDING(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .seg_count (seg_count),
    .finished  (finished)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  seg_t exp_q[$];
  int   exp_total = 0;
  seg_t mon_seg;
  int   hs_count = 0, auto_sent = 0, man_sent = 0, man_req = 0;
  logic auto_done = 1'b0, bp = 1'b0, rdy_main = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bcd_t to_bcd(input longint v);
    bcd_t r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int dec_len(input longint v);
    int n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic longint p10(input int n);
    longint r = 1;
    repeat (n) r = r * 10;
    return r;
  endfunction

  // Reference split: every even digit count between the bounds' lengths
  task automatic push_range(input longint s, input longint e);
    int ls, le;
    seg_t x;
    ls = dec_len(s);
    le = dec_len(e);
    if (s <= e) begin
      for (int l = ls; l <= le; l++) begin
        if (l % 2 == 0) begin
          x.s = to_bcd((l == ls) ? s : p10(l - 1));
          x.e = to_bcd((l == le) ? e : p10(l) - 1);
          x.l = 4'(l);
          exp_q.push_back(x);
          exp_total++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic send_range(input longint s, input longint e);
    logic [79:0] w;
    int t;
    w = {to_bcd(s), to_bcd(e)};
    push_range(s, e);
    for (int i = 0; i < 3; i++) begin
      bus.in_data  = (i == 2) ? {16'h0, w[79:64]} : w[32*i +: 32];
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 100) begin
        step();
        t++;
      end
      check_eq("in_ready_wait", t < 100, 1);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      step();
      t++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_finished(input string tag);
    int t = 0;
    while (!finished && t < 200) begin
      step();
      t++;
    end
    check_eq(tag, finished, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    auto_done = 1'b0;
    bp = 1'b0;
    rdy_main = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    exp_total = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs_count < target && t < 300) begin
      step();
      t++;
    end
    check_eq("hs_wait", hs_count >= target, 1);
  endtask

  // Monitor and datapath model: pops the scoreboard on handshakes, returns seg_done pulses
  initial begin
    bus.seg_done  = 1'b0;
    bus.seg_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && bus.seg_valid && bus.seg_ready) begin
        hs_count++;
        check_eq("seg_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_seg = exp_q.pop_front();
          check_eq("seg_start", bus.seg_start, mon_seg.s);
          check_eq("seg_end", bus.seg_end, mon_seg.e);
          check_eq("seg_len", bus.seg_len, mon_seg.l);
        end
      end
      @(posedge clk);
      #2;
      if (!auto_done) auto_sent = hs_count;
      if (auto_done && auto_sent < hs_count) begin
        bus.seg_done = 1'b1;
        auto_sent++;
      end else if (man_sent < man_req) begin
        bus.seg_done = 1'b1;
        man_sent++;
      end else begin
        bus.seg_done = 1'b0;
      end
      bus.seg_ready = bp ? ($urandom_range(0, 1) == 1) : rdy_main;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values, then in_ready after release
    step();
    step();
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_seg_valid", bus.seg_valid, 0);
    check_eq("rst_seg_len", bus.seg_len, 0);
    check_eq("rst_seg_start", bus.seg_start, 0);
    check_eq("rst_seg_count", seg_count, 0);
    check_eq("rst_finished", finished, 0);
    rst_n = 1'b1;
    step();
    check_eq("in_ready_after_rst", bus.in_ready, 1);

    // 11..22 and 95..115 with an immediate datapath, then completion
    auto_done = 1'b1;
    send_range(11, 22);
    check_eq("in_ready_drop", bus.in_ready, 0);
    check_eq("lat_cycle1", bus.seg_valid, 0);
    step();
    check_eq("lat_cycle2", bus.seg_valid, 0);
    wait_drained("drain_11_22");
    send_range(95, 115);
    wait_drained("drain_95_115");
    wait_finished("finished_two");
    check_eq("count_two", seg_count, 16'(exp_total));
    check_eq("done_in_ready", bus.in_ready, 0);
    check_eq("done_seg_valid", bus.seg_valid, 0);

    // 5..123456 under random backpressure, plus an inverted range
    do_reset();
    check_eq("finished_cleared", finished, 0);
    auto_done = 1'b1;
    bp = 1'b1;
    send_range(5, 123456);
    send_range(40, 30);
    wait_drained("drain_5_123456");
    wait_finished("finished_bp");
    check_eq("count_three", seg_count, 16'(exp_total));

    // Credit limit: two segments in flight block the third until a seg_done
    do_reset();
    base = hs_count;
    send_range(5, 123456);
    wait_hs(base + 2);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("credit_block", bus.seg_valid, 0);
    end
    check_eq("credit_out_full", dut.out_q, 2);
    man_req = man_req + 1;
    step();
    check_eq("credit_done_cycle", bus.seg_valid, 0);
    step();
    check_eq("credit_resume", bus.seg_valid, 1);
    wait_drained("drain_credit");
    check_eq("credit_out_after", dut.out_q, 2);

    // Handshake coinciding with seg_done at MAX_OUTSTANDING-1
    do_reset();
    base = hs_count;
    send_range(11, 22);
    wait_hs(base + 1);
    check_eq("sim_out_before", dut.out_q, 1);
    rdy_main = 1'b0;
    send_range(5, 123456);
    base = 0;
    while (!bus.seg_valid && base < 100) begin
      step();
      base++;
    end
    check_eq("sim_valid_wait", bus.seg_valid, 1);
    rdy_main = 1'b1;
    man_req = man_req + 1;
    step();
    step();
    check_eq("sim_out_after", dut.out_q, 1);
    check_eq("sim_count", seg_count, 2);

    // Reset mid-EMIT, then 998..1012 and 40..30 to completion
    do_reset();
    base = hs_count;
    send_range(5, 123456);
    wait_hs(base + 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", bus.seg_valid, 0);
    check_eq("async_rst_count", seg_count, 0);
    exp_q.delete();
    exp_total = 0;
    step();
    step();
    rst_n = 1'b1;
    send_range(998, 1012);
    send_range(40, 30);
    wait_drained("drain_998_1012");
    repeat (4) step();
    check_eq("drain_not_finished", finished, 0);
    check_eq("post_rst_count", seg_count, 16'(exp_total));
    man_req = man_req + 1;
    step();
    check_eq("finish_done_cycle", finished, 0);
    step();
    check_eq("finish_after_done", finished, 1);
    repeat (3) step();
    check_eq("finish_sticky", finished, 1);
    check_eq("no_stale_seg", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/range_scheduler.md
RANGE_SCHEDULER -- requirements
Module: range_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have parameter NUM_RANGES, default 34, giving the number of input ranges in the puzzle.
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default 8, giving the maximum number of segments in flight in the datapath.
REQ-004 The block SHALL have port clk, input, 1 bit: clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_data, input, 32 bits: packed range word stream.
REQ-007 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): input handshake.
REQ-008 The block SHALL have ports seg_start and seg_end, output, 40 bits each: BCD segment bounds, 10 digits.
REQ-009 The block SHALL have port seg_len, output, 4 bits: digit count of the segment (even, 2..10).
REQ-010 The block SHALL have ports seg_valid (output, 1 bit) and seg_ready (input, 1 bit): segment handshake to the sum datapath.
REQ-011 The block SHALL have port seg_done, input, 1 bit: one-cycle pulse from the datapath per completed segment.
REQ-012 The block SHALL have port seg_count, output, 16 bits: total segments issued.
REQ-013 The block SHALL have port finished, output, 1 bit: sticky; all ranges split and all segments completed.

Function
REQ-014 FSM states SHALL be COLLECT, SPLIT, EMIT, DRAIN and DONE.
REQ-015 COLLECT: in_ready=1 while ranges accepted < NUM_RANGES.
- Words 0, 1 and 2 fill buffer bits [31:0], [63:32] and [79:64] respectively; word 2 uses in_data[15:0] only.
- start = buf[79:40], end = buf[39:0].
REQ-016 The handshake on word 2 SHALL move the FSM to SPLIT.
- in_ready=0 from the next cycle until the FSM returns to COLLECT.
REQ-017 SPLIT (one cycle) SHALL register lenS/lenE and set cur_len=lenS.
- lenS/lenE = 1 + index of the most-significant nonzero nibble; all-zero = 1.
REQ-018 EMIT, for each cur_len from lenS to lenE:
- Odd cur_len: consumes exactly one cycle with seg_valid=0.
- Even cur_len: seg_start = start if cur_len==lenS, else BCD 10^(cur_len-1).
- Even cur_len: seg_end = end if cur_len==lenE, else cur_len nines.
- seg_len = cur_len.
REQ-019 If start > end (numeric BCD compare), SPLIT SHALL skip EMIT and emit no segments.
REQ-020 seg_valid, seg_start, seg_end and seg_len SHALL be held stable until the cycle where seg_valid && seg_ready.
- cur_len advances on that cycle.
REQ-021 The first seg_valid SHALL assert no earlier than 2 cycles after the word-2 handshake.
REQ-022 Credit: outstanding increments on a segment handshake and decrements on seg_done.
- Simultaneous increment and decrement: unchanged.
- seg_done with outstanding==0: ignored.
REQ-023 seg_valid SHALL be 0 while outstanding == MAX_OUTSTANDING.
REQ-024 After cur_len > lenE, the FSM SHALL go to COLLECT if ranges accepted < NUM_RANGES, else to DRAIN.
REQ-025 DRAIN SHALL go to DONE when outstanding==0.
- DONE sets finished=1 until reset.
- In DONE, in_ready=0 and seg_valid=0.
REQ-026 seg_count SHALL increment on each segment handshake and saturate at 16'hFFFF.

Reset
REQ-027 rst_n=0 SHALL asynchronously force:
- FSM to COLLECT.
- Word counter, range counter, outstanding, seg_count, seg_valid, finished, seg_start, seg_end and seg_len to 0.
REQ-028 Reset mid-EMIT SHALL discard the partial range; no stale segment appears after release.
REQ-029 in_ready SHALL rise in the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package gift_shop_pkg SHALL hold:
- BCD_W=40 and WORD_W=32.
- The FSM state enum.
- The BCD power-of-ten and all-nines constant tables.
REQ-031 Sub-module bcd_digit_len (combinational, 40-bit BCD in, 4-bit length out) SHALL be instantiated twice (start and end).

Verification
REQ-032 Range 11..22: one segment, 0x11..0x22, len 2.
REQ-033 Range 95..115: one segment, 0x95..0x99, len 2; len 3 skipped with no seg_valid.
REQ-034 Range 5..123456: three segments:
- 0x10..0x99, len 2.
- 0x1000..0x9999, len 4.
- 0x100000..0x123456, len 6.
REQ-035 MAX_OUTSTANDING=2, seg_ready=1, no seg_done: seg_valid drops after 2 handshakes, and resumes the cycle after a seg_done pulse.
REQ-036 Reset mid-EMIT of range 5..123456, then ranges 998..1012 and 40..30 with NUM_RANGES=2:
- One segment, 0x1000..0x1012, len 4.
- finished=1 one cycle after its seg_done.
REQ-037 A simultaneous handshake and seg_done at outstanding=MAX_OUTSTANDING-1 SHALL leave outstanding unchanged.
